// File: rtl/pid_pkg.sv
// Shared types and constants for the PID actuator output stage.
package pid_pkg;

    // Width of the signed control word produced by the PID.
    localparam int CTRL_W = 16;

    // Operating states of the PWM output stage.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

    // True when the counter width, period and sample point form a usable
    // combination: the period fits the counter, the clamp can slice the
    // control word, and the PID strobe lands at least one cycle before the wrap.
    function automatic bit pwmParamsOk(input int cntW, input int period, input int sampleAt);
        bit ok;
        ok = (cntW >= 1) && (cntW <= CTRL_W);
        ok = ok && (period >= 4) && (period <= (2 ** cntW) - 1);
        ok = ok && (sampleAt >= 0) && (sampleAt <= period - 2);
        return ok;
    endfunction

endpackage

// File: rtl/pid_pwm_out_if.sv
// Control/status bundle between the PID side and the PWM output stage.
interface pid_pwm_out_if
    import pid_pkg::*;
#(
    parameter int CNT_W = 12
);

    logic                     run;
    logic signed [CTRL_W-1:0] control;
    logic                     pwm;
    logic                     pid_en;
    logic [CNT_W-1:0]         duty;
    logic                     sat_hi;
    logic                     sat_lo;
    logic                     busy;

    // The PID/supervisor side drives run and control and watches the status.
    modport master (
        output run, control,
        input  pwm, pid_en, duty, sat_hi, sat_lo, busy
    );

    // The output stage consumes run and control and drives everything else.
    modport slave (
        input  run, control,
        output pwm, pid_en, duty, sat_hi, sat_lo, busy
    );

endinterface

// File: rtl/pid_duty_clamp.sv
// Combinational clamp of the signed control word into the legal duty range 0..PERIOD.
module pid_duty_clamp
    import pid_pkg::*;
#(
    parameter int CNT_W  = 12,
    parameter int PERIOD = 1000
) (
    input  logic signed [CTRL_W-1:0] control_i,
    output logic [CNT_W-1:0]         duty_o,
    output logic                     hi_o,
    output logic                     lo_o
);

    localparam logic signed [CTRL_W:0] PERIOD_S = (CTRL_W + 1)'(PERIOD);
    localparam logic [CNT_W-1:0]       PERIOD_U = CNT_W'(PERIOD);

    // One extra bit keeps the comparison against PERIOD safely signed.
    logic signed [CTRL_W:0] ctrlExt;
    assign ctrlExt = {control_i[CTRL_W-1], control_i};

    // Negative words floor at zero, words beyond PERIOD cap at PERIOD; exactly 0 and PERIOD pass unflagged.
    always_comb begin
        duty_o = control_i[CNT_W-1:0];
        hi_o   = 1'b0;
        lo_o   = 1'b0;
        if (control_i[CTRL_W-1]) begin
            duty_o = '0;
            lo_o   = 1'b1;
        end else if (ctrlExt > PERIOD_S) begin
            duty_o = PERIOD_U;
            hi_o   = 1'b1;
        end
    end

endmodule

// File: rtl/pid_pwm_out.sv
// PWM actuator stage: period counter, run/drain FSM, double-buffered duty and PID pacing strobe.
module pid_pwm_out
    import pid_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int PERIOD    = 1000,
    parameter int SAMPLE_AT = 0
) (
    input  logic          clk,
    input  logic          reset,
    pid_pwm_out_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_AT);

    // Refuse to elaborate with a parameter set the counter or strobe timing cannot honour.
    if (!pwmParamsOk(CNT_W, PERIOD, SAMPLE_AT)) begin : gBadParams
        $error("pid_pwm_out: illegal CNT_W/PERIOD/SAMPLE_AT combination");
    end

    pwm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             satHi_q, satHi_d;
    logic             satLo_q, satLo_d;
    logic             pwm_q, pwm_d;
    logic             pidEn_q, pidEn_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] clampDuty;
    logic             clampHi;
    logic             clampLo;
    logic             wrap;
    logic             load;

    pid_duty_clamp #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) uClamp (
        .control_i (bus.control),
        .duty_o    (clampDuty),
        .hi_o      (clampHi),
        .lo_o      (clampLo)
    );

    assign wrap = (cnt_q == LAST_CNT);

    // Next-state logic; the duty buffer only reloads on a start or on a wrap that stays active.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        satHi_d = satHi_q;
        satLo_d = satLo_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.run) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
                load  = wrap;
                if (!bus.run) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
                if (bus.run) begin
                    state_d = RUN;
                    load    = wrap;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            duty_d  = clampDuty;
            satHi_d = clampHi;
            satLo_d = clampLo;
        end

        pwm_d   = (state_d != IDLE) && (cnt_d < duty_d);
        pidEn_d = (state_d == RUN) && (cnt_d == SAMPLE_CNT);
        busy_d  = (state_d != IDLE);
    end

    // State, counter and every output are registered together so they always agree cycle for cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            duty_q  <= '0;
            satHi_q <= 1'b0;
            satLo_q <= 1'b0;
            pwm_q   <= 1'b0;
            pidEn_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            satHi_q <= satHi_d;
            satLo_q <= satLo_d;
            pwm_q   <= pwm_d;
            pidEn_q <= pidEn_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.pwm    = pwm_q;
    assign bus.pid_en = pidEn_q;
    assign bus.duty   = duty_q;
    assign bus.sat_hi = satHi_q;
    assign bus.sat_lo = satLo_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_pid_pwm_out.sv
// Scoreboard bench for pid_pwm_out with PERIOD=10, SAMPLE_AT=2, CNT_W=4.
module tb_pid_pwm_out;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    typedef struct {
        logic  pwm;
        logic  pidEn;
        int    duty;
        logic  hi;
        logic  lo;
        logic  busy;
        string tag;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t expQ[$];
    exp_t mon;

    pid_pwm_out_if #(.CNT_W(4)) bus ();

    pid_pwm_out #(
        .CNT_W     (4),
        .PERIOD    (10),
        .SAMPLE_AT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue what the outputs must show after the next rising edge.
    task automatic applyStimulus(input logic r, input int c, input int st, input int ecnt,
                                 input int eduty, input logic ehi, input logic elo, input string tag);
        exp_t e;
        @(negedge clk);
        bus.run     = r;
        bus.control = 16'(c);
        e.pwm   = (st != S_IDLE) && (ecnt < eduty);
        e.pidEn = (st == S_RUN) && (ecnt == 2);
        e.duty  = eduty;
        e.hi    = ehi;
        e.lo    = elo;
        e.busy  = (st != S_IDLE);
        e.tag   = $sformatf("%s cnt%0d", tag, ecnt);
        expQ.push_back(e);
    endtask

    // A run of consecutive cycles sharing inputs and expected state, with the counter stepping fromCnt..toCnt.
    task automatic runSpan(input logic r, input int c, input int st, input int fromCnt, input int toCnt,
                           input int eduty, input logic ehi, input logic elo, input string tag);
        for (int i = fromCnt; i <= toCnt; i++) begin
            applyStimulus(r, c, st, i, eduty, ehi, elo, tag);
        end
    endtask

    // Monitor: shortly after each rising edge, compare the DUT against the oldest queued expectation.
    always begin
        @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            mon = expQ.pop_front();
            checkOutput({mon.tag, " pwm"},    int'(bus.pwm),    int'(mon.pwm));
            checkOutput({mon.tag, " pid_en"}, int'(bus.pid_en), int'(mon.pidEn));
            checkOutput({mon.tag, " duty"},   int'(bus.duty),   mon.duty);
            checkOutput({mon.tag, " sat_hi"}, int'(bus.sat_hi), int'(mon.hi));
            checkOutput({mon.tag, " sat_lo"}, int'(bus.sat_lo), int'(mon.lo));
            checkOutput({mon.tag, " busy"},   int'(bus.busy),   int'(mon.busy));
        end
    end

    // Directed scenarios: reset, nominal duty, saturation, buffering, drain, re-arm and async reset.
    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        bus.run     = 1'b0;
        bus.control = '0;

        #2;
        checkOutput("reset pwm",    int'(bus.pwm),    0);
        checkOutput("reset pid_en", int'(bus.pid_en), 0);
        checkOutput("reset duty",   int'(bus.duty),   0);
        checkOutput("reset sat_hi", int'(bus.sat_hi), 0);
        checkOutput("reset sat_lo", int'(bus.sat_lo), 0);
        checkOutput("reset busy",   int'(bus.busy),   0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] nominal duty 3");
        applyStimulus(1, 3, S_RUN, 0, 3, 0, 0, "s1 start");
        runSpan(1, 3, S_RUN, 1, 9, 3, 0, 0, "s1 p1");
        runSpan(1, 3, S_RUN, 0, 9, 3, 0, 0, "s1 p2");

        $display("[TB] saturation");
        runSpan(1, -5, S_RUN, 0, 9, 0, 0, 1, "s2 neg");
        runSpan(1, 20, S_RUN, 0, 9, 10, 1, 0, "s2 big");
        runSpan(1, 10, S_RUN, 0, 9, 10, 0, 0, "s2 full");
        runSpan(1, 0,  S_RUN, 0, 9, 0, 0, 0, "s2 zero");

        $display("[TB] mid-period change");
        runSpan(1, 3, S_RUN, 0, 4, 3, 0, 0, "s3 old");
        runSpan(1, 7, S_RUN, 5, 9, 3, 0, 0, "s3 held");
        runSpan(1, 7, S_RUN, 0, 9, 7, 0, 0, "s3 new");

        $display("[TB] drain to idle");
        runSpan(1, 3, S_RUN,   0, 4, 3, 0, 0, "s4 run");
        runSpan(0, 9, S_DRAIN, 5, 9, 3, 0, 0, "s4 drain");
        runSpan(0, 9, S_IDLE,  0, 2, 3, 0, 0, "s4 idle");

        $display("[TB] drain across sample point, re-arm on wrap");
        applyStimulus(1, 6, S_RUN, 0, 6, 0, 0, "s4b start");
        runSpan(0, 6, S_DRAIN, 1, 9, 6, 0, 0, "s4b drain");
        applyStimulus(1, 2, S_RUN, 0, 2, 0, 0, "s4b rearm");
        runSpan(0, 2, S_DRAIN, 1, 9, 2, 0, 0, "s4b drain2");
        applyStimulus(0, 2, S_IDLE, 0, 2, 0, 0, "s4b idle");

        $display("[TB] drain re-arm mid-period");
        applyStimulus(1, 3, S_RUN, 0, 3, 0, 0, "s5 start");
        runSpan(1, 3, S_RUN,   1, 4, 3, 0, 0, "s5 run");
        runSpan(0, 5, S_DRAIN, 5, 6, 3, 0, 0, "s5 drain");
        runSpan(1, 5, S_RUN,   7, 9, 3, 0, 0, "s5 rearm");
        runSpan(1, 5, S_RUN,   0, 9, 5, 0, 0, "s5 reload");

        $display("[TB] async reset mid-period");
        runSpan(1, 5, S_RUN, 0, 1, 5, 0, 0, "s6 pre");
        @(posedge clk);
        #3;
        reset   = 1'b1;
        bus.run = 1'b0;
        #1;
        checkOutput("async reset pwm",    int'(bus.pwm),    0);
        checkOutput("async reset pid_en", int'(bus.pid_en), 0);
        checkOutput("async reset busy",   int'(bus.busy),   0);
        checkOutput("async reset duty",   int'(bus.duty),   0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        runSpan(0, 4, S_IDLE, 0, 2, 0, 0, 0, "s6 idle");
        applyStimulus(1, 4, S_RUN, 0, 4, 0, 0, "s6 restart");
        runSpan(1, 4, S_RUN, 1, 3, 4, 0, 0, "s6 run");

        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        #3;
        if (expQ.size() != 0) begin
            checkOutput("scoreboard drained", expQ.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
